// File: rtl/wavepool_pkg.sv
// Shared defaults, wavefront id type and the range-checked one-hot decoder
// used by every id decoder in the wavepool controller.
package wavepool_pkg;

  localparam int NUM_WF_DEF      = 40;
  localparam int WFID_W_DEF      = 6;
  localparam int QUEUE_DEPTH_DEF = 16;
  localparam int CNT_W_DEF       = 5;

  // Widest slot vector the decoder can produce; callers truncate to NUM_WF.
  localparam int WF_MAX = 256;

  typedef logic [WFID_W_DEF-1:0] wfid_t;

  // One-hot decode of id; ids at or beyond n (the slot count) decode to zero.
  function automatic logic [WF_MAX-1:0] onehot_wfid(input logic [31:0] id,
                                                    input int unsigned n);
    logic [WF_MAX-1:0] r;
    r = '0;
    if ((id < n) && (id < 32'(WF_MAX))) r = WF_MAX'(1) << id;
    return r;
  endfunction

endpackage

// File: rtl/wp_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting slot strictly after ptr,
// wrapping at NUM_WF. Purely combinational.
module wp_rr_arbiter
  import wavepool_pkg::*;
#(
  parameter int NUM_WF = NUM_WF_DEF,
  parameter int WFID_W = WFID_W_DEF
) (
  input  logic [NUM_WF-1:0] req,
  input  logic [WFID_W-1:0] ptr,
  output logic [NUM_WF-1:0] gnt,
  output logic [WFID_W-1:0] gnt_id,
  output logic              gnt_valid
);

  // Scan ptr+1 .. ptr+NUM_WF (mod NUM_WF) and keep the first hit.
  always_comb begin
    gnt       = '0;
    gnt_id    = '0;
    gnt_valid = 1'b0;
    for (int k = 1; k <= NUM_WF; k++) begin
      if (!gnt_valid && req[(int'(ptr) + k) % NUM_WF]) begin
        gnt[(int'(ptr) + k) % NUM_WF] = 1'b1;
        gnt_id    = WFID_W'((int'(ptr) + k) % NUM_WF);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wavepool_controller_rr.sv
// Wavepool controller: per-wavefront valid, queue occupancy and branch-pending
// tracking with round-robin issue to decode.
// Optional macro WP_RECOVER_EN adds recover_en/recover_wfid, which flush a slot.
//
// Decode handshake: there is no valid/ready pair back from decode. A grant
// (q_rd) is produced only in a cycle where decode_ready is high, and the
// transfer completes in that same cycle; decode_wfid/decode_instr_valid then
// report that transfer one cycle later.
module wavepool_controller_rr
  import wavepool_pkg::*;
#(
  parameter int NUM_WF      = NUM_WF_DEF,
  parameter int WFID_W      = WFID_W_DEF,
  parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WFID_W-1:0] buff_wfid,
  input  logic              buff_first,
  input  logic              buff_ack,
  output logic [NUM_WF-1:0] q_wr,
  output logic              buff_overflow,
  input  logic [WFID_W-1:0] reserve_slotid,
  input  logic              reserve_valid,
  output logic [NUM_WF-1:0] q_vtail_incr,
  input  logic [WFID_W-1:0] halt_wfid,
  input  logic              wf_halt,
  input  logic [WFID_W-1:0] branch_issued_wfid,
  input  logic              branch_issued,
  input  logic [WFID_W-1:0] branch_wfid,
  input  logic              branch_en,
  input  logic              branch_taken,
`ifdef WP_RECOVER_EN
  input  logic              recover_en,
  input  logic [WFID_W-1:0] recover_wfid,
`endif
  output logic [NUM_WF-1:0] q_reset,
  input  logic              decode_ready,
  output logic [NUM_WF-1:0] q_rd,
  output logic [NUM_WF-1:0] valid_wf,
  output logic [WFID_W-1:0] decode_wfid,
  output logic              decode_instr_valid
);

  function automatic logic [NUM_WF-1:0] dec(input logic [WFID_W-1:0] id);
    return NUM_WF'(onehot_wfid(32'(id), NUM_WF));
  endfunction

  logic [NUM_WF-1:0][CNT_W-1:0] count;
  logic [NUM_WF-1:0]            br_pend;
  logic [WFID_W-1:0]            rr_ptr;

  logic [NUM_WF-1:0] buff_oh, halt_oh, bri_oh, br_oh, rec_term;
  logic [NUM_WF-1:0] full_vec, elig, req;
  logic              valid_at, full_at, reset_at, wr_ok;
  logic [WFID_W-1:0] gnt_id;
  logic              gnt_valid;

  assign buff_oh = dec(buff_wfid);
  assign halt_oh = dec(halt_wfid);
  assign bri_oh  = dec(branch_issued_wfid);
  assign br_oh   = dec(branch_wfid);

`ifdef WP_RECOVER_EN
  assign rec_term = dec(recover_wfid) & {NUM_WF{recover_en}};
`else
  assign rec_term = '0;
`endif

  assign q_vtail_incr = dec(reserve_slotid) & {NUM_WF{reserve_valid}};
  assign q_reset      = (halt_oh & {NUM_WF{wf_halt}})
                      | (br_oh & {NUM_WF{branch_en & branch_taken}})
                      | rec_term;

  // Per-slot full flag and issue eligibility.
  always_comb begin
    full_vec = '0;
    elig     = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      full_vec[i] = (count[i] == CNT_W'(QUEUE_DEPTH));
      elig[i]     = valid_wf[i] & (count[i] != '0) & ~br_pend[i] & ~q_reset[i];
    end
  end

  // An out-of-range buff_wfid leaves buff_oh zero, so every *_at term is 0.
  assign valid_at      = |(buff_oh & valid_wf);
  assign full_at       = |(buff_oh & full_vec);
  assign reset_at      = |(buff_oh & q_reset);
  assign wr_ok         = buff_ack & (buff_first | valid_at) & ~full_at & ~reset_at;
  assign q_wr          = buff_oh & {NUM_WF{wr_ok}};
  assign buff_overflow = buff_ack & full_at & ~reset_at;

  assign req = elig & {NUM_WF{decode_ready}};

  wp_rr_arbiter #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) u_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .gnt       (q_rd),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  // Occupancy counters: flush wins, otherwise net of write and read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      for (int i = 0; i < NUM_WF; i++) begin
        if (q_reset[i])               count[i] <= '0;
        else if (q_wr[i] && !q_rd[i]) count[i] <= count[i] + 1'b1;
        else if (!q_wr[i] && q_rd[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  // Valid and branch-pending flags: flush wins, branch resolve beats issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_wf <= '0;
      br_pend  <= '0;
    end else begin
      for (int i = 0; i < NUM_WF; i++) begin
        if (q_reset[i]) begin
          valid_wf[i] <= 1'b0;
          br_pend[i]  <= 1'b0;
        end else begin
          if (q_wr[i] && buff_first) valid_wf[i] <= 1'b1;
          if (br_oh[i] && branch_en)            br_pend[i] <= 1'b0;
          else if (bri_oh[i] && branch_issued)  br_pend[i] <= 1'b1;
        end
      end
    end
  end

  // Round-robin pointer and registered decode issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr             <= WFID_W'(NUM_WF - 1);
      decode_wfid        <= '0;
      decode_instr_valid <= 1'b0;
    end else begin
      decode_instr_valid <= gnt_valid;
      if (gnt_valid) begin
        rr_ptr      <= gnt_id;
        decode_wfid <= gnt_id;
      end
    end
  end

endmodule

// File: tb/tb_wavepool_controller_rr.sv
// Self-checking bench for wavepool_controller_rr: decoder vector table,
// hand-written corner sequences and randomized traffic, all compared against
// a slot-array reference model.
module tb_wavepool_controller_rr;

  localparam int NWF = 40;
  localparam int QD  = 16;

  typedef struct {
    logic [5:0] buff_wfid;
    logic       buff_first;
    logic       buff_ack;
    logic [5:0] reserve_slotid;
    logic       reserve_valid;
    logic [5:0] halt_wfid;
    logic       wf_halt;
    logic [5:0] bi_wfid;
    logic       bi;
    logic [5:0] br_wfid;
    logic       br_en;
    logic       br_taken;
    logic       decode_ready;
    logic       rec_en;
    logic [5:0] rec_wfid;
  } in_t;

  typedef struct {
    in_t         in;
    logic [39:0] exp_vtail;
    logic [39:0] exp_qreset;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [5:0]  buff_wfid, reserve_slotid, halt_wfid, branch_issued_wfid, branch_wfid;
  logic        buff_first, buff_ack, reserve_valid, wf_halt, branch_issued;
  logic        branch_en, branch_taken, decode_ready;
  logic        recover_en;
  logic [5:0]  recover_wfid;
  logic [39:0] q_wr, q_vtail_incr, q_reset, q_rd, valid_wf;
  logic        buff_overflow, decode_instr_valid;
  logic [5:0]  decode_wfid;

  wavepool_controller_rr dut (
    .clk                (clk),
    .rst                (rst),
    .buff_wfid          (buff_wfid),
    .buff_first         (buff_first),
    .buff_ack           (buff_ack),
    .q_wr               (q_wr),
    .buff_overflow      (buff_overflow),
    .reserve_slotid     (reserve_slotid),
    .reserve_valid      (reserve_valid),
    .q_vtail_incr       (q_vtail_incr),
    .halt_wfid          (halt_wfid),
    .wf_halt            (wf_halt),
    .branch_issued_wfid (branch_issued_wfid),
    .branch_issued      (branch_issued),
    .branch_wfid        (branch_wfid),
    .branch_en          (branch_en),
    .branch_taken       (branch_taken),
`ifdef WP_RECOVER_EN
    .recover_en         (recover_en),
    .recover_wfid       (recover_wfid),
`endif
    .q_reset            (q_reset),
    .decode_ready       (decode_ready),
    .q_rd               (q_rd),
    .valid_wf           (valid_wf),
    .decode_wfid        (decode_wfid),
    .decode_instr_valid (decode_instr_valid)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit          m_valid[NWF];
  int          m_cnt[NWF];
  bit          m_bp[NWF];
  int          m_ptr;
  bit          m_dec_v;
  int          m_dec_id;
  in_t         cur;
  logic [39:0] e_wr, e_rd, e_qr, e_vt;
  bit          e_ovf, e_gv;
  int          e_gid;

  function automatic logic [39:0] oh(input int id);
    logic [39:0] r;
    r = '0;
    if (id >= 0 && id < NWF) r[id] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NWF; i++) begin
      m_valid[i] = 0; m_cnt[i] = 0; m_bp[i] = 0;
    end
    m_ptr = NWF - 1; m_dec_v = 0; m_dec_id = 0;
  endtask

  task automatic model_comb();
    int bid, s;
    e_qr = (cur.wf_halt ? oh(int'(cur.halt_wfid)) : 40'h0)
         | ((cur.br_en && cur.br_taken) ? oh(int'(cur.br_wfid)) : 40'h0);
`ifdef WP_RECOVER_EN
    e_qr = e_qr | (cur.rec_en ? oh(int'(cur.rec_wfid)) : 40'h0);
`endif
    e_vt  = cur.reserve_valid ? oh(int'(cur.reserve_slotid)) : 40'h0;
    bid   = int'(cur.buff_wfid);
    e_wr  = '0;
    e_ovf = 0;
    if (cur.buff_ack && bid < NWF && !e_qr[bid]) begin
      if (m_cnt[bid] == QD) e_ovf = 1;
      else if (cur.buff_first || m_valid[bid]) e_wr[bid] = 1'b1;
    end
    e_rd = '0; e_gv = 0; e_gid = 0;
    if (cur.decode_ready) begin
      for (int k = 1; k <= NWF; k++) begin
        s = (m_ptr + k) % NWF;
        if (!e_gv && m_valid[s] && m_cnt[s] > 0 && !m_bp[s] && !e_qr[s]) begin
          e_gv = 1; e_gid = s; e_rd[s] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < NWF; i++) begin
      if (e_qr[i]) begin
        m_valid[i] = 0; m_cnt[i] = 0; m_bp[i] = 0;
      end else begin
        m_cnt[i] = m_cnt[i] + int'(e_wr[i]) - int'(e_rd[i]);
        if (e_wr[i] && cur.buff_first) m_valid[i] = 1;
        if (cur.br_en && int'(cur.br_wfid) == i) m_bp[i] = 0;
        else if (cur.bi && int'(cur.bi_wfid) == i) m_bp[i] = 1;
      end
    end
    m_dec_v = e_gv;
    if (e_gv) begin
      m_ptr = e_gid; m_dec_id = e_gid;
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic in_t idle_in();
    in_t x;
    x = '{default: '0};
    return x;
  endfunction

  function automatic in_t wr_in(input int id, input bit first, input bit rdy);
    in_t x;
    x = idle_in();
    x.buff_wfid = 6'(id); x.buff_ack = 1'b1; x.buff_first = first; x.decode_ready = rdy;
    return x;
  endfunction

  task automatic drive(input in_t x);
    cur                = x;
    buff_wfid          = x.buff_wfid;
    buff_first         = x.buff_first;
    buff_ack           = x.buff_ack;
    reserve_slotid     = x.reserve_slotid;
    reserve_valid      = x.reserve_valid;
    halt_wfid          = x.halt_wfid;
    wf_halt            = x.wf_halt;
    branch_issued_wfid = x.bi_wfid;
    branch_issued      = x.bi;
    branch_wfid        = x.br_wfid;
    branch_en          = x.br_en;
    branch_taken       = x.br_taken;
    decode_ready       = x.decode_ready;
    recover_en         = x.rec_en;
    recover_wfid       = x.rec_wfid;
  endtask

  // Drive at the falling edge, then compare one unit later against the model.
  task automatic apply(input in_t x);
    logic [39:0] mv;
    drive(x);
    #1;
    model_comb();
    for (int i = 0; i < NWF; i++) mv[i] = m_valid[i];
    chk("q_wr", 64'(q_wr), 64'(e_wr));
    chk("q_rd", 64'(q_rd), 64'(e_rd));
    chk("q_reset", 64'(q_reset), 64'(e_qr));
    chk("q_vtail_incr", 64'(q_vtail_incr), 64'(e_vt));
    chk("buff_overflow", 64'(buff_overflow), 64'(e_ovf));
    chk("valid_wf", 64'(valid_wf), 64'(mv));
    chk("decode_instr_valid", 64'(decode_instr_valid), 64'(m_dec_v));
    chk("decode_wfid", 64'(decode_wfid), 64'(m_dec_id));
  endtask

  task automatic clock();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic step(input in_t x);
    apply(x);
    clock();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    apply(idle_in());
    chk("rst_valid_wf", 64'(valid_wf), 64'h0);
    chk("rst_decode_valid", 64'(decode_instr_valid), 64'h0);
    chk("rst_decode_wfid", 64'(decode_wfid), 64'h0);
    clock();
    rst = 1'b1;
  endtask

  function automatic vec_t mkv(input int rid, input bit rv, input int hid, input bit hv,
                               input int bid, input bit ben, input bit btk,
                               input logic [39:0] ev, input logic [39:0] eq);
    vec_t v;
    v.in = idle_in();
    v.in.reserve_slotid = 6'(rid); v.in.reserve_valid = rv;
    v.in.halt_wfid = 6'(hid); v.in.wf_halt = hv;
    v.in.br_wfid = 6'(bid); v.in.br_en = ben; v.in.br_taken = btk;
    v.exp_vtail = ev; v.exp_qreset = eq;
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    vec_t tbl[9];
    in_t  x;
    bit   found;

    tbl[0] = mkv(0,  1, 0,  0, 0,  0, 0, 40'h1,                     40'h0);
    tbl[1] = mkv(39, 1, 0,  0, 0,  0, 0, 40'h80_0000_0000,           40'h0);
    tbl[2] = mkv(40, 1, 0,  0, 0,  0, 0, 40'h0,                     40'h0);
    tbl[3] = mkv(63, 1, 0,  0, 0,  0, 0, 40'h0,                     40'h0);
    tbl[4] = mkv(5,  0, 0,  0, 0,  0, 0, 40'h0,                     40'h0);
    tbl[5] = mkv(0,  0, 9,  1, 0,  0, 0, 40'h0,                     40'h200);
    tbl[6] = mkv(0,  0, 0,  0, 7,  1, 1, 40'h0,                     40'h80);
    tbl[7] = mkv(0,  0, 0,  0, 7,  1, 0, 40'h0,                     40'h0);
    tbl[8] = mkv(20, 1, 50, 1, 11, 1, 1, 40'h10_0000,               40'h800);

    drive(idle_in());
    @(negedge clk);
    do_reset();

    // Decoder vectors
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].in);
      chk("tbl_vtail", 64'(q_vtail_incr), 64'(tbl[i].exp_vtail));
      chk("tbl_qreset", 64'(q_reset), 64'(tbl[i].exp_qreset));
      clock();
    end

    // Reset with slots 3 and 5 loaded, then round-robin 3,5,3
    step(wr_in(3, 1, 0)); step(wr_in(5, 1, 0));
    do_reset();
    step(wr_in(3, 1, 0)); step(wr_in(3, 0, 0));
    step(wr_in(5, 1, 0)); step(wr_in(5, 0, 0));
    x = idle_in(); x.decode_ready = 1'b1;
    apply(x); chk("rr_first", 64'(q_rd), 64'h8); clock();
    apply(x); chk("rr_second", 64'(q_rd), 64'h20);
    chk("rr_dec_id1", 64'(decode_wfid), 64'd3); clock();
    apply(x); chk("rr_third", 64'(q_rd), 64'h8);
    chk("rr_dec_id2", 64'(decode_wfid), 64'd5); clock();
    step(x); step(x);

    // 17 writes to slot 2 with decode stalled
    do_reset();
    for (int i = 0; i < 17; i++) begin
      apply(wr_in(2, i == 0, 0));
      if (i < 16) chk("fill_q_wr", 64'(q_wr), 64'h4);
      else begin
        chk("ovf_q_wr", 64'(q_wr), 64'h0);
        chk("ovf_flag", 64'(buff_overflow), 64'h1);
      end
      clock();
    end
    x = idle_in(); x.decode_ready = 1'b1;
    step(x);

    // Branch stall on slot 7
    do_reset();
    step(wr_in(7, 1, 0));
    for (int i = 0; i < 3; i++) step(wr_in(7, 0, 0));
    x = idle_in(); x.bi = 1'b1; x.bi_wfid = 6'd7;
    step(x);
    x = idle_in(); x.decode_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      apply(x); chk("br_stall", 64'(q_rd[7]), 64'h0); clock();
    end
    x.br_en = 1'b1; x.br_wfid = 6'd7; x.br_taken = 1'b0;
    step(x);
    x = idle_in(); x.decode_ready = 1'b1;
    found = 0;
    for (int i = 0; i < NWF && !found; i++) begin
      apply(x);
      if (q_rd[7]) found = 1;
      clock();
    end
    chk("br_granted", 64'(found), 64'h1);
    x = idle_in(); x.br_en = 1'b1; x.br_wfid = 6'd7; x.br_taken = 1'b1;
    apply(x); chk("br_taken_reset", 64'(q_reset), 64'h80); clock();
    apply(idle_in()); chk("br_taken_valid", 64'(valid_wf[7]), 64'h0); clock();
    step(wr_in(7, 0, 1));

    // Halt and write to sole eligible slot 9 in the same cycle
    do_reset();
    step(wr_in(9, 1, 0));
    x = wr_in(9, 0, 1); x.wf_halt = 1'b1; x.halt_wfid = 6'd9;
    apply(x);
    chk("halt_q_wr", 64'(q_wr), 64'h0);
    chk("halt_q_rd", 64'(q_rd), 64'h0);
    clock();
    apply(idle_in());
    chk("halt_dec_valid", 64'(decode_instr_valid), 64'h0);
    chk("halt_valid", 64'(valid_wf[9]), 64'h0);
    clock();
    step(wr_in(9, 1, 1));

    // Out-of-range id
    apply(wr_in(45, 1, 0)); chk("oor_q_wr", 64'(q_wr), 64'h0); clock();
    apply(idle_in()); chk("oor_valid", 64'(valid_wf), 64'h200); clock();

`ifdef WP_RECOVER_EN
    x = idle_in(); x.rec_en = 1'b1; x.rec_wfid = 6'd12;
    apply(x); chk("recover_reset", 64'(q_reset), 64'h1000); clock();
`endif

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      x = idle_in();
      x.buff_wfid      = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      x.buff_ack       = ($urandom_range(0, 9) < 7);
      x.buff_first     = ($urandom_range(0, 9) < 2);
      x.reserve_slotid = 6'($urandom_range(0, 47));
      x.reserve_valid  = 1'($urandom_range(0, 1));
      x.halt_wfid      = 6'($urandom_range(0, 9));
      x.wf_halt        = ($urandom_range(0, 19) == 0);
      x.bi_wfid        = 6'($urandom_range(0, 7));
      x.bi             = ($urandom_range(0, 9) == 0);
      x.br_wfid        = 6'($urandom_range(0, 7));
      x.br_en          = ($urandom_range(0, 9) == 0);
      x.br_taken       = 1'($urandom_range(0, 1));
      x.decode_ready   = ($urandom_range(0, 9) < 6);
      x.rec_wfid       = 6'($urandom_range(0, 7));
      x.rec_en         = ($urandom_range(0, 29) == 0);
      step(x);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
